// File: rtl/boot_loader_if.sv
// Byte-stream ingress and instruction-memory write bus of the boot loader.
// The slave modport is the loader's view; the master modport is the byte source /
// memory side.
interface boot_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/boot_loader.sv
// Byte-stream program loader. It optionally zeroes the instruction memory, then takes a
// length-prefixed image followed by a checksum byte and writes the image from address 0.
// The CPU is held in reset until the image checks out. A bad checksum or a stalled
// stream parks the loader in a sticky error state until the next reset.
module boot_loader #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter bit          CLEAR_EN = 1'b1,
    parameter int unsigned RST_HOLD = 2,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.slave  bus,
    output logic          cpu_rst_n,
    output logic          load_done,
    output logic          err
);

    // Length counts up to 2**ADDR_W, so it needs one bit more than an address.
    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int unsigned IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
    localparam logic [LEN_W-1:0]  LEN_FULL  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        StClear,
        StLen,
        StData,
        StChk,
        StRelease,
        StRun,
        StError
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] clr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  ptr_q;
    logic [DATA_W-1:0] sum_q;
    logic [IDLE_W-1:0] idle_q;
    logic [HOLD_W-1:0] hold_q;

    logic              accept;
    logic [LEN_W-1:0]  ptr_inc;
    logic [DATA_W-1:0] sum_nxt;
    logic              idle_expired;

    // Handshake, running pointer/sum and idle-limit helpers for the FSM.
    always_comb begin
        accept       = 1'b0;
        ptr_inc      = '0;
        sum_nxt      = '0;
        idle_expired = 1'b0;
        accept       = bus.byte_valid & bus.byte_ready;
        ptr_inc      = ptr_q + LEN_W'(1);
        sum_nxt      = sum_q + bus.byte_in;
        idle_expired = (idle_q == IDLE_MAX);
    end

    // Load sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CLEAR_EN ? StClear : StLen;
            clr_q          <= '0;
            len_q          <= '0;
            ptr_q          <= '0;
            sum_q          <= '0;
            idle_q         <= '0;
            hold_q         <= '0;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_rst_n      <= 1'b0;
            load_done      <= 1'b0;
            err            <= 1'b0;
        end else begin
            // Writes are single-cycle pulses; only the branches below raise the strobe.
            bus.imem_we <= 1'b0;

            unique case (state_q)
                StClear: begin
                    bus.imem_we    <= 1'b1;
                    bus.imem_addr  <= clr_q;
                    bus.imem_wdata <= '0;
                    clr_q          <= clr_q + 1'b1;
                    if (clr_q == '1) begin
                        state_q        <= StLen;
                        bus.byte_ready <= 1'b1;
                    end
                end

                StLen: begin
                    // Also covers the first cycle after reset when the clear is skipped.
                    bus.byte_ready <= 1'b1;
                    if (accept) begin
                        len_q   <= (bus.byte_in == '0) ? LEN_FULL : LEN_W'(bus.byte_in);
                        ptr_q   <= '0;
                        sum_q   <= '0;
                        idle_q  <= '0;
                        state_q <= StData;
                    end
                end

                StData: begin
                    if (idle_expired) begin
                        state_q        <= StError;
                        bus.byte_ready <= 1'b0;
                        err            <= 1'b1;
                    end else if (accept) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= ptr_q[ADDR_W-1:0];
                        bus.imem_wdata <= bus.byte_in;
                        ptr_q          <= ptr_inc;
                        sum_q          <= sum_nxt;
                        idle_q         <= '0;
                        // Leave on the L-th byte so address 0 is never written twice.
                        if (ptr_inc == len_q) begin
                            state_q <= StChk;
                        end
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end

                StChk: begin
                    if (idle_expired) begin
                        state_q        <= StError;
                        bus.byte_ready <= 1'b0;
                        err            <= 1'b1;
                    end else if (accept) begin
                        bus.byte_ready <= 1'b0;
                        idle_q         <= '0;
                        if (sum_nxt == '0) begin
                            state_q <= StRelease;
                            hold_q  <= '0;
                        end else begin
                            state_q <= StError;
                            err     <= 1'b1;
                        end
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end

                StRelease: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q   <= StRun;
                        cpu_rst_n <= 1'b1;
                        load_done <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end

                StRun: begin
                    state_q <= StRun;
                end

                StError: begin
                    state_q <= StError;
                end

                default: begin
                    // Unused encoding: fail safe with the CPU held in reset.
                    state_q        <= StError;
                    bus.byte_ready <= 1'b0;
                    cpu_rst_n      <= 1'b0;
                    load_done      <= 1'b0;
                    err            <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader. Expected memory writes come from a queue filled by a
// behavioural model of the image format; a negedge process checks every write and the
// global status invariants against it.
module tb_boot_loader;

    logic clk = 1'b0;
    logic rst;
    logic cpu_rst_n;
    logic load_done;
    logic err;

    boot_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    boot_loader #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .CLEAR_EN (1'b1),
        .RST_HOLD (2),
        .TIMEOUT  (1023)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .load_done (load_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];       // {addr, data} of each expected memory write, in order
    logic [7:0]  img[$];
    logic [7:0]  model_sum;
    bit          model_good;
    logic [15:0] cmp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: memory writes against the model queue, plus status invariants.
    always @(negedge clk) begin
        check("cpu_rst_vs_done", cpu_rst_n, load_done);
        check("done_err_excl", load_done & err, 0);
        if (err) check("err_not_ready", bus.byte_ready, 0);
        if (bus.imem_we === 1'b1) begin
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                cmp_e = exp_q.pop_front();
                check("write_addr", bus.imem_addr, cmp_e[15:8]);
                check("write_data", bus.imem_wdata, cmp_e[7:0]);
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_ready", bus.byte_ready, 0);
        check("rst_we", bus.imem_we, 0);
        check("rst_addr", bus.imem_addr, 0);
        check("rst_wdata", bus.imem_wdata, 0);
        check("rst_cpu", cpu_rst_n, 0);
        check("rst_done", load_done, 0);
        check("rst_err", err, 0);
    endtask

    // Entered at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int w = 0;
        while (!bus.byte_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", bus.byte_ready, 1);
        if (bus.byte_ready) begin
            bus.byte_in    = b;
            bus.byte_valid = 1'b1;
            @(negedge clk);
            bus.byte_valid = 1'b0;
        end
    endtask

    // Reset, then expect a full zero-fill of the memory, one address per cycle.
    task automatic reset_and_clear(input bit noise);
        rst            = 1'b1;
        bus.byte_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        exp_q.delete();
        check_reset_vals();
        rst = 1'b0;
        for (int a = 0; a < 256; a++) exp_q.push_back({8'(a), 8'h00});
        for (int i = 0; i < 256; i++) begin
            if (noise && i < 250) begin
                bus.byte_valid = 1'($urandom_range(0, 1));
                bus.byte_in    = 8'($urandom_range(0, 255));
            end else begin
                bus.byte_valid = 1'b0;
            end
            @(negedge clk);
            check("clear_we", bus.imem_we, 1);
            check("clear_addr", bus.imem_addr, i[7:0]);
            check("clear_ready", bus.byte_ready, i == 255);
        end
        bus.byte_valid = 1'b0;
        @(negedge clk);
        check("len_we", bus.imem_we, 0);
        check("len_ready", bus.byte_ready, 1);
        check("len_cpu", cpu_rst_n, 0);
        check("len_err", err, 0);
    endtask

    // Model the image in img[], queue its writes, stream it, and check the outcome.
    task automatic run_image();
        int l;
        int s;
        l = (img[0] == 8'h00) ? 256 : int'(img[0]);
        s = 0;
        for (int i = 0; i < l; i++) begin
            exp_q.push_back({8'(i), img[i + 1]});
            s += int'(img[i + 1]);
        end
        model_sum  = 8'(s);
        model_good = (8'(s + int'(img[l + 1])) == 8'h00);
        foreach (img[i]) send(img[i]);
        if (model_good) begin
            check("rel_ready", bus.byte_ready, 0);
            check("rel_cpu_0", cpu_rst_n, 0);
            @(negedge clk);
            check("rel_cpu_1", cpu_rst_n, 0);
            @(negedge clk);
            check("run_cpu", cpu_rst_n, 1);
            check("run_done", load_done, 1);
            check("run_err", err, 0);
            check("run_ready", bus.byte_ready, 0);
        end else begin
            check("bad_err", err, 1);
            check("bad_cpu", cpu_rst_n, 0);
            check("bad_ready", bus.byte_ready, 0);
            check("bad_done", load_done, 0);
        end
        check("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        @(negedge clk);
        check_reset_vals();

        // Clear, then good 3-byte image: 11+22+33 = 66, 66+9A wraps to 0.
        reset_and_clear(1'b0);
        img.delete();
        img.push_back(8'h03); img.push_back(8'h11); img.push_back(8'h22);
        img.push_back(8'h33); img.push_back(8'h9A);
        run_image();
        check("pin_sum_good", model_sum, 8'h66);
        check("pin_good", model_good, 1);

        // Bad checksum: sticky error, later valid pulses write nothing.
        reset_and_clear(1'b0);
        img.delete();
        img.push_back(8'h03); img.push_back(8'h11); img.push_back(8'h22);
        img.push_back(8'h33); img.push_back(8'h00);
        run_image();
        check("pin_bad", model_good, 0);
        for (int k = 0; k < 4; k++) begin
            bus.byte_in    = 8'h77;
            bus.byte_valid = k[0];
            @(negedge clk);
            check("err_no_we", bus.imem_we, 0);
            check("err_sticky", err, 1);
        end
        bus.byte_valid = 1'b0;

        // Length 0 means a full 256-byte image; 256 * 01 wraps to 0.
        reset_and_clear(1'b0);
        img.delete();
        img.push_back(8'h00);
        for (int i = 0; i < 256; i++) img.push_back(8'h01);
        img.push_back(8'h00);
        run_image();
        check("pin_full_sum", model_sum, 8'h00);
        check("pin_full_good", model_good, 1);
        repeat (5) @(negedge clk);
        check("full_done_hold", load_done, 1);
        check("full_no_we", bus.imem_we, 0);

        // Stall after the first of two data bytes: error exactly after TIMEOUT idle cycles.
        reset_and_clear(1'b0);
        exp_q.push_back({8'h00, 8'hAA});
        send(8'h02);
        send(8'hAA);
        repeat (1023) @(negedge clk);
        check("tmo_not_yet", err, 0);
        check("tmo_ready_still", bus.byte_ready, 1);
        @(negedge clk);
        check("tmo_err", err, 1);
        check("tmo_ready", bus.byte_ready, 0);
        check("tmo_cpu", cpu_rst_n, 0);
        check("tmo_writes", exp_q.size(), 0);

        // Reset mid-image with noisy valid: clear restarts at 0, then a fresh load works.
        reset_and_clear(1'b0);
        exp_q.push_back({8'h00, 8'h11});
        send(8'h03);
        send(8'h11);
        reset_and_clear(1'b1);
        img.delete();
        img.push_back(8'h01); img.push_back(8'h5A); img.push_back(8'hA6);
        run_image();
        check("pin_recover_sum", model_sum, 8'h5A);
        check("pin_recover_good", model_good, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
